// File: rtl/sysbus_pkg.sv
// Shared types and constants for the Sysbus memory responder.
package sysbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_WAIT,
    ST_RESP,
    ST_WDATA,
    ST_WDONE
  } state_e;

  localparam int BEATS      = 8;
  localparam int BEAT_W     = 3;
  localparam int LINE_OFS_W = 6;

  // The write flag is always the top bit of the tag, whatever its width.
  function automatic int wr_flag_bit(input int tag_width);
    return tag_width - 1;
  endfunction

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response channel between the cache arbiter and the memory responder.
interface sysbus_if #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 13
);
  logic                 reqcyc;
  logic [WIDTH-1:0]     req;
  logic [TAG_WIDTH-1:0] reqtag;
  logic                 reqack;
  logic                 respcyc;
  logic [WIDTH-1:0]     resp;
  logic [TAG_WIDTH-1:0] resptag;
  logic                 respack;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/sysbus_mem_array.sv
// Single-port synchronous word array with registered read.
module sysbus_mem_array #(
  parameter int    WIDTH     = 64,
  parameter int    DEPTH     = 4096,
  parameter int    AW        = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sysbus_mem_responder.sv
// Behavioural DRAM at the far end of the Sysbus: line reads as 8-beat bursts after a fixed latency, line writes.
module sysbus_mem_responder
  import sysbus_pkg::*;
#(
  parameter int    WIDTH     = 64,
  parameter int    TAG_WIDTH = 13,
  parameter int    MEM_WORDS = 4096,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input logic     clk,
  input logic     reset,
  sysbus_if.slave bus
);

  localparam int AW     = $clog2(MEM_WORDS);
  localparam int LINE_W = AW - BEAT_W;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int WR_BIT = wr_flag_bit(TAG_WIDTH);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

  state_e               state_q, state_d;
  logic [LINE_W-1:0]    line_q, line_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [BEAT_W-1:0]    beat_q, beat_d, beat_inc;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 reqack_q, reqack_d;
  logic                 respcyc_q, respcyc_d;
  logic                 mem_we, mem_re;
  logic [AW-1:0]        mem_addr;
  logic [WIDTH-1:0]     mem_rdata;

  assign beat_inc = beat_q + BEAT_W'(1);

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    tag_d     = tag_q;
    beat_d    = beat_q;
    cnt_d     = cnt_q;
    reqack_d  = 1'b0;
    respcyc_d = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = {line_q, beat_q};
    case (state_q)
      ST_IDLE: begin
        if (bus.reqcyc) begin
          line_d   = bus.req[AW+2:LINE_OFS_W];
          tag_d    = bus.reqtag;
          reqack_d = 1'b1;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: begin
        // Beat 0 is fetched early so the first resp beat comes straight out of the array register.
        mem_re   = 1'b1;
        mem_addr = {line_q, BEAT_W'(0)};
        beat_d   = '0;
        if (tag_q[WR_BIT]) begin
          state_d = ST_WDATA;
        end else if (LATENCY == 1) begin
          respcyc_d = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_re   = 1'b1;
        mem_addr = {line_q, BEAT_W'(0)};
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          respcyc_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        mem_re    = 1'b1;
        respcyc_d = 1'b1;
        if (bus.respack) begin
          mem_addr = {line_q, beat_inc};
          beat_d   = beat_inc;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            respcyc_d = 1'b0;
            beat_d    = '0;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_WDATA: begin
        if (bus.reqcyc) begin
          mem_we = 1'b1;
          beat_d = beat_inc;
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            reqack_d = 1'b1;
            state_d  = ST_WDONE;
          end
        end
      end
      ST_WDONE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      line_q    <= '0;
      tag_q     <= '0;
      beat_q    <= '0;
      cnt_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      tag_q     <= tag_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
    end
  end

  sysbus_mem_array #(
    .WIDTH    (WIDTH),
    .DEPTH    (MEM_WORDS),
    .AW       (AW),
    .INIT_FILE(INIT_FILE)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .we_i   (mem_we && !reset),
    .re_i   (mem_re),
    .addr_i (mem_addr),
    .wdata_i(bus.req),
    .rdata_o(mem_rdata)
  );

  assign bus.reqack  = reqack_q;
  assign bus.respcyc = respcyc_q;
  assign bus.resp    = mem_rdata;
  assign bus.resptag = tag_q;

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: directed reads, stalls, writes, wrap, back-to-back and reset.
module tb_sysbus_mem_responder;
  import sysbus_pkg::*;

  localparam int LATENCY   = 4;
  localparam int MEM_WORDS = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [63:0] exp_data[$];
  logic [12:0] exp_tag[$];

  sysbus_if #(.WIDTH(64), .TAG_WIDTH(13)) bus ();

  sysbus_mem_responder #(
    .WIDTH(64), .TAG_WIDTH(13), .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY), .INIT_FILE("")
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted read beat is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.respcyc && bus.respack) begin
      if (exp_data.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: beat %h tag %h but nothing expected", bus.resp, bus.resptag);
      end else begin
        check("sb_data", bus.resp, exp_data.pop_front());
        check("sb_tag", 64'(bus.resptag), 64'(exp_tag.pop_front()));
      end
    end
  end

  task automatic push_line(input logic [12:0] tag, input logic [63:0] d0, input int n);
    for (int i = 0; i < n; i++) begin
      exp_data.push_back(d0 + 64'(i));
      exp_tag.push_back(tag);
    end
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [12:0] tag,
                          input logic [63:0] d0, input bit gap);
    bus.reqcyc = 1'b1; bus.req = addr; bus.reqtag = tag;
    @(posedge clk); #1;
    bus.reqcyc = 1'b0;
    check("wr_ack", 64'(bus.reqack), 64'd1);
    @(posedge clk); #1;
    check("wr_ack_pulse", 64'(bus.reqack), 64'd0);
    for (int i = 0; i < 8; i++) begin
      bus.reqcyc = 1'b1; bus.req = d0 + 64'(i);
      @(posedge clk); #1;
      if (gap && i == 2) begin
        bus.reqcyc = 1'b0;
        @(posedge clk); #1;
        check("wr_gap_no_ack", 64'(bus.reqack), 64'd0);
      end
    end
    bus.reqcyc = 1'b0;
    check("wr_done", 64'(bus.reqack), 64'd1);
    check("wr_no_resp", 64'(bus.respcyc), 64'd0);
    @(posedge clk); #1;
    check("wr_done_pulse", 64'(bus.reqack), 64'd0);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic [12:0] tag,
                         input logic [63:0] d0, input int stall0, input int stall4);
    int lat, acc, cyc, s0, s4;
    push_line(tag, d0, 8);
    bus.reqcyc = 1'b1; bus.req = addr; bus.reqtag = tag; bus.respack = 1'b0;
    @(posedge clk); #1;
    bus.reqcyc = 1'b0;
    check("rd_ack", 64'(bus.reqack), 64'd1);
    lat = 1;
    while (!bus.respcyc && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) check("rd_ack_pulse", 64'(bus.reqack), 64'd0);
    end
    check("rd_latency", 64'(lat), 64'(1 + LATENCY));
    acc = 0; cyc = 0; s0 = 0; s4 = 0;
    while (acc < 8 && cyc < 60) begin
      check("rd_valid", 64'(bus.respcyc), 64'd1);
      if (acc == 0 && s0 < stall0) begin
        bus.respack = 1'b0; s0++;
      end else if (acc == 4 && s4 < stall4) begin
        bus.respack = 1'b0; s4++;
      end else begin
        bus.respack = 1'b1;
      end
      @(posedge clk); #1;
      if (bus.respack) acc++;
      cyc++;
    end
    bus.respack = 1'b0;
    check("rd_beats", 64'(acc), 64'd8);
    check("rd_drop", 64'(bus.respcyc), 64'd0);
    check("rd_sb_empty", 64'(exp_data.size()), 64'd0);
  endtask

  initial begin
    int cyc, last_resp, ack2, acc;
    bus.reqcyc = 1'b0; bus.req = '0; bus.reqtag = '0; bus.respack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_reqack", 64'(bus.reqack), 64'd0);
    check("rst_respcyc", 64'(bus.respcyc), 64'd0);
    check("rst_resp", bus.resp, 64'd0);
    check("rst_resptag", 64'(bus.resptag), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Preload line at word 8 (byte 0x40) with 0x100..0x107.
    do_write(64'h40, 13'h1001, 64'h100, 1'b0);
    do_read(64'h40, 13'h005, 64'h100, 0, 0);
    do_read(64'h40, 13'h005, 64'h100, 3, 2);
    do_write(64'h80, 13'h1003, 64'hA0, 1'b1);
    do_read(64'h80, 13'h003, 64'hA0, 0, 0);
    do_read(64'h47, 13'h011, 64'h100, 0, 0);
    do_read(64'(MEM_WORDS * 8 + 'h40), 13'h012, 64'h100, 1, 0);

    // Back-to-back: reqcyc held, tag changed after the first acceptance.
    push_line(13'h005, 64'h100, 8);
    push_line(13'h00A, 64'h100, 8);
    bus.reqcyc = 1'b1; bus.req = 64'h40; bus.reqtag = 13'h005; bus.respack = 1'b1;
    @(posedge clk); #1;
    check("b2b_ack1", 64'(bus.reqack), 64'd1);
    bus.reqtag = 13'h00A;
    cyc = 1; last_resp = 0; ack2 = 0;
    while (ack2 == 0 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.respcyc) last_resp = cyc;
      if (bus.reqack) ack2 = cyc;
    end
    bus.reqcyc = 1'b0;
    check("b2b_ack2_gap", 64'(ack2 - last_resp), 64'd2);
    cyc = 0;
    while ((exp_data.size() != 0 || bus.respcyc) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus.respack = 1'b0;
    check("b2b_drain", 64'(exp_data.size()), 64'd0);
    check("b2b_drop", 64'(bus.respcyc), 64'd0);

    // Reset while beat 4 is presented.
    push_line(13'h007, 64'h100, 4);
    bus.reqcyc = 1'b1; bus.req = 64'h40; bus.reqtag = 13'h007;
    @(posedge clk); #1;
    bus.reqcyc = 1'b0;
    cyc = 0;
    while (!bus.respcyc && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    bus.respack = 1'b1;
    acc = 0;
    while (acc < 4 && cyc < 80) begin
      @(posedge clk); #1;
      acc++; cyc++;
    end
    reset = 1'b1; bus.respack = 1'b0;
    @(posedge clk); #1;
    check("rrst_respcyc", 64'(bus.respcyc), 64'd0);
    check("rrst_reqack", 64'(bus.reqack), 64'd0);
    check("rrst_resptag", 64'(bus.resptag), 64'd0);
    check("rrst_state", 64'(dut.state_q), 64'(ST_IDLE));
    check("rrst_sb_empty", 64'(exp_data.size()), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    do_read(64'h40, 13'h009, 64'h100, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

endmodule
